// File: rtl/regfile_write_arbiter_if.sv
// Handshake and write-port bundle between the pipeline/long-latency unit
// (master side) and the register-file write arbiter (slave side).
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mc_issue;
    logic [ADDR_W-1:0] mc_issue_rd;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_rd;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
        input  mc_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
        output mc_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: pipeline write-back has priority, late
// long-latency results are queued (or bypassed when the port is free), and a
// scoreboard of pending destinations drives the decode hazard stall.
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int NREG         = 16,
    parameter int ADDR_W       = 4,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    regfile_write_arbiter_if.slave bus,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    input  logic [ADDR_W-1:0]   rd_chk,
    output logic                hazard_stall,
    output logic                wb_hold,
    output logic [NREG-1:0]     busy_mask,
    output logic [1:0]          q_count
);
    localparam logic [1:0]    DEPTH   = 2'(LQ_DEPTH);
    localparam int            SW      = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SW-1:0] HOLD_AT = SW'(STARVE_LIMIT - 1);

    logic [ADDR_W-1:0] q_rd     [LQ_DEPTH];
    logic [DATA_W-1:0] q_data   [LQ_DEPTH];
    logic [ADDR_W-1:0] q_rd_n   [LQ_DEPTH];
    logic [DATA_W-1:0] q_data_n [LQ_DEPTH];
    logic [1:0]        cnt, cnt_mid, cnt_n;
    logic [SW-1:0]     starve;
    logic [NREG-1:0]   busy, set_mask, clr_mask;
    logic              mc_ready, accept, q_empty, pop, bypass, push;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign q_empty  = (cnt == '0);
    assign mc_ready = reset & (cnt < DEPTH);
    assign accept   = bus.mc_valid & mc_ready;
    assign pop      = ~bus.wb_valid & ~q_empty;
    assign bypass   = ~bus.wb_valid & q_empty & accept;
    assign push     = accept & ~bypass;

    assign bus.mc_ready = mc_ready;
    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = rf_waddr;
    assign bus.rf_wdata = rf_wdata;

    assign q_count      = cnt;
    assign busy_mask    = busy;
    assign hazard_stall = busy[rs1_addr] | busy[rs2_addr] | busy[rd_chk];
    assign wb_hold      = (starve >= HOLD_AT);

    // Shift-register queue next state: head is slot 0; a pop shifts down
    // first, then a push lands at the post-pop occupancy so FIFO order holds.
    always_comb begin
        cnt_mid = pop  ? cnt - 2'd1     : cnt;
        cnt_n   = push ? cnt_mid + 2'd1 : cnt_mid;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if (pop) begin
                q_rd_n[i]   = q_rd[(i + 1 < LQ_DEPTH) ? i + 1 : i];
                q_data_n[i] = q_data[(i + 1 < LQ_DEPTH) ? i + 1 : i];
            end else begin
                q_rd_n[i]   = q_rd[i];
                q_data_n[i] = q_data[i];
            end
            if (push && (i == 32'(cnt_mid))) begin
                q_rd_n[i]   = bus.mc_rd;
                q_data_n[i] = bus.mc_data;
            end
        end
    end

    // Scoreboard update masks: issue sets, the write of an mc result clears.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.mc_issue) set_mask[bus.mc_issue_rd] = 1'b1;
        if (pop)          clr_mask[q_rd[0]]         = 1'b1;
        else if (bypass)  clr_mask[bus.mc_rd]       = 1'b1;
    end

    // Queue payload storage; validity is tracked solely by cnt.
    always_ff @(posedge clk) begin
        q_rd   <= q_rd_n;
        q_data <= q_data_n;
    end

    // Occupancy, scoreboard and starvation counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            busy   <= '0;
            starve <= '0;
        end else begin
            cnt  <= cnt_n;
            busy <= (busy & ~clr_mask) | set_mask;
            if (q_empty || pop)
                starve <= '0;
            else if (bus.wb_valid && (starve != '1))
                starve <= starve + 1'b1;
        end
    end

    // Registered write port: pipeline, then queue head, then bypass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (bus.wb_valid) begin
            rf_we    <= 1'b1;
            rf_waddr <= bus.wb_addr;
            rf_wdata <= bus.wb_data;
        end else if (!q_empty) begin
            rf_we    <= 1'b1;
            rf_waddr <= q_rd[0];
            rf_wdata <= q_data[0];
        end else if (accept) begin
            rf_we    <= 1'b1;
            rf_waddr <= bus.mc_rd;
            rf_wdata <= bus.mc_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected register-file writes go
// into a scoreboard queue as stimulus is issued; a negedge monitor pops and
// compares every write the DUT performs. Side signals are checked inline.
module tb_regfile_write_arbiter;
    logic        clk;
    logic        reset;
    logic [3:0]  rs1_addr, rs2_addr, rd_chk;
    logic        hazard_stall, wb_hold;
    logic [15:0] busy_mask;
    logic [1:0]  q_count;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    regfile_write_arbiter #(
        .DATA_W(32), .NREG(16), .ADDR_W(4), .LQ_DEPTH(2), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_chk(rd_chk),
        .hazard_stall(hazard_stall), .wb_hold(wb_hold),
        .busy_mask(busy_mask), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_wb(input logic v, input logic [3:0] a, input logic [31:0] d);
        bus.wb_valid = v;
        bus.wb_addr  = a;
        bus.wb_data  = d;
    endtask

    task automatic drive_mc(input logic v, input logic [3:0] a, input logic [31:0] d);
        bus.mc_valid = v;
        bus.mc_rd    = a;
        bus.mc_data  = d;
    endtask

    task automatic issue(input logic [3:0] rd);
        bus.mc_issue    = 1'b1;
        bus.mc_issue_rd = rd;
        step();
        bus.mc_issue    = 1'b0;
    endtask

    // Monitor: every register-file write must match the next expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.rf_we === 1'b1) begin
            assertions++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rf_write_unexpected: got addr %0d data 0x%0h, expected no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
                    failures++;
                    $display("FAIL rf_write: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                             bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        rd_chk   = '0;
        drive_wb(1'b0, '0, '0);
        drive_mc(1'b0, '0, '0);
        bus.mc_issue    = 1'b0;
        bus.mc_issue_rd = '0;
        #2 reset = 1'b0;
        step();
        step();

        // Reset state
        check("reset_rf_we", 64'(bus.rf_we), 64'd0);
        check("reset_rf_waddr", 64'(bus.rf_waddr), 64'd0);
        check("reset_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        check("reset_busy", 64'(busy_mask), 64'd0);
        check("reset_q_count", 64'(q_count), 64'd0);
        check("reset_mc_ready", 64'(bus.mc_ready), 64'd0);
        check("reset_wb_hold", 64'(wb_hold), 64'd0);
        reset = 1'b1;
        #1;
        check("release_mc_ready", 64'(bus.mc_ready), 64'd1);
        step();

        // Pipeline write only
        drive_wb(1'b1, 4'd3, 32'h1234);
        expect_wr(4'd3, 32'h1234);
        step();
        drive_wb(1'b0, '0, '0);
        check("wb_rf_we", 64'(bus.rf_we), 64'd1);
        step();
        check("wb_idle_rf_we", 64'(bus.rf_we), 64'd0);

        // Bypass of a late result into an idle port
        issue(4'd5);
        check("bypass_busy_set", 64'(busy_mask), 64'h0020);
        rs1_addr = 4'd5;
        #1;
        check("bypass_hazard_rs1", 64'(hazard_stall), 64'd1);
        rs1_addr = 4'd0;
        rd_chk   = 4'd5;
        #1;
        check("bypass_hazard_rd", 64'(hazard_stall), 64'd1);
        rd_chk   = 4'd4;
        #1;
        check("bypass_no_hazard", 64'(hazard_stall), 64'd0);
        rd_chk   = 4'd0;
        step();
        step();
        step();
        drive_mc(1'b1, 4'd5, 32'hCAFE);
        check("bypass_mc_ready", 64'(bus.mc_ready), 64'd1);
        expect_wr(4'd5, 32'hCAFE);
        step();
        drive_mc(1'b0, '0, '0);
        check("bypass_rf_we", 64'(bus.rf_we), 64'd1);
        check("bypass_busy_clear", 64'(busy_mask), 64'd0);
        check("bypass_q_count", 64'(q_count), 64'd0);

        // Conflict: pipeline wins, mc result queued then written
        issue(4'd7);
        drive_wb(1'b1, 4'd2, 32'h11);
        drive_mc(1'b1, 4'd7, 32'h77);
        expect_wr(4'd2, 32'h11);
        expect_wr(4'd7, 32'h77);
        step();
        drive_wb(1'b0, '0, '0);
        drive_mc(1'b0, '0, '0);
        check("conflict_q_count_1", 64'(q_count), 64'd1);
        check("conflict_busy_held", 64'(busy_mask), 64'h0080);
        step();
        check("conflict_q_count_0", 64'(q_count), 64'd0);
        check("conflict_busy_clear", 64'(busy_mask), 64'd0);
        step();
        check("conflict_idle", 64'(bus.rf_we), 64'd0);

        // Full queue: two accepted, third held until space frees
        issue(4'd8);
        issue(4'd9);
        issue(4'd10);
        check("full_busy", 64'(busy_mask), 64'h0700);
        drive_wb(1'b1, 4'd1, 32'hA1);
        drive_mc(1'b1, 4'd8, 32'h88);
        expect_wr(4'd1, 32'hA1);
        step();
        check("full_q_1", 64'(q_count), 64'd1);
        drive_wb(1'b1, 4'd1, 32'hA2);
        drive_mc(1'b1, 4'd9, 32'h99);
        expect_wr(4'd1, 32'hA2);
        step();
        check("full_q_2", 64'(q_count), 64'd2);
        check("full_mc_ready_0", 64'(bus.mc_ready), 64'd0);
        drive_wb(1'b1, 4'd1, 32'hA3);
        drive_mc(1'b1, 4'd10, 32'hAA);
        expect_wr(4'd1, 32'hA3);
        step();
        check("full_q_held", 64'(q_count), 64'd2);
        check("full_busy_held", 64'(busy_mask), 64'h0700);
        drive_wb(1'b0, '0, '0);
        expect_wr(4'd8, 32'h88);
        expect_wr(4'd9, 32'h99);
        expect_wr(4'd10, 32'hAA);
        step();
        check("drain_q_1", 64'(q_count), 64'd1);
        check("drain_mc_ready_1", 64'(bus.mc_ready), 64'd1);
        check("drain_busy_a", 64'(busy_mask), 64'h0600);
        step();
        drive_mc(1'b0, '0, '0);
        check("drain_push_pop_q", 64'(q_count), 64'd1);
        check("drain_busy_b", 64'(busy_mask), 64'h0400);
        step();
        check("drain_q_0", 64'(q_count), 64'd0);
        check("drain_busy_c", 64'(busy_mask), 64'd0);

        // Starvation: queued entry blocked by continuous pipeline writes
        issue(4'd11);
        drive_wb(1'b1, 4'd1, 32'hB0);
        drive_mc(1'b1, 4'd11, 32'hBB);
        expect_wr(4'd1, 32'hB0);
        step();
        drive_mc(1'b0, '0, '0);
        check("starve_q_1", 64'(q_count), 64'd1);
        check("starve_hold_0", 64'(wb_hold), 64'd0);
        for (int i = 1; i <= 7; i++) begin
            drive_wb(1'b1, 4'd1, 32'hB0 + 32'(i));
            expect_wr(4'd1, 32'hB0 + 32'(i));
            step();
            check($sformatf("starve_hold_c%0d", i), 64'(wb_hold), (i == 7) ? 64'd1 : 64'd0);
        end
        drive_wb(1'b0, '0, '0);
        expect_wr(4'd11, 32'hBB);
        step();
        check("starve_released", 64'(wb_hold), 64'd0);
        check("starve_q_0", 64'(q_count), 64'd0);
        check("starve_busy", 64'(busy_mask), 64'd0);

        // Asynchronous reset with a full queue and pending destinations
        issue(4'd7);
        issue(4'd10);
        drive_wb(1'b1, 4'd1, 32'hC1);
        drive_mc(1'b1, 4'd7, 32'h70);
        expect_wr(4'd1, 32'hC1);
        step();
        drive_wb(1'b1, 4'd1, 32'hC2);
        drive_mc(1'b1, 4'd10, 32'hA0);
        expect_wr(4'd1, 32'hC2);
        step();
        drive_wb(1'b0, '0, '0);
        drive_mc(1'b0, '0, '0);
        check("pre_reset_q", 64'(q_count), 64'd2);
        check("pre_reset_busy", 64'(busy_mask), 64'h0480);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_reset_rf_we", 64'(bus.rf_we), 64'd0);
        check("mid_reset_rf_waddr", 64'(bus.rf_waddr), 64'd0);
        check("mid_reset_q", 64'(q_count), 64'd0);
        check("mid_reset_busy", 64'(busy_mask), 64'd0);
        check("mid_reset_mc_ready", 64'(bus.mc_ready), 64'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("post_reset_mc_ready", 64'(bus.mc_ready), 64'd1);
        check("post_reset_q", 64'(q_count), 64'd0);
        step();
        drive_wb(1'b1, 4'd4, 32'hDEAD);
        expect_wr(4'd4, 32'hDEAD);
        step();
        drive_wb(1'b0, '0, '0);
        check("post_reset_rf_we", 64'(bus.rf_we), 64'd1);
        step();
        step();

        check("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
